mult_div_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, alongside the single-cycle ALU, for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It accepts one operation per start pulse, runs a fixed-length shift-add or restoring-divide sequence, and holds the 2N-bit result in architectural HI/LO registers. The hazard logic stalls on `busy`; MFHI/MFLO read `hi`/`lo` directly.

---
 rtl/mult_div_unit.sv | 138 +++++++++++++
 tb/tb_mult_div_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide over N cycles,
// followed by a sign-fix cycle that writes the architectural HI/LO registers.
module mult_div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] srcA,
    input  logic [N-1:0] srcB,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic [1:0]   dbg_state
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Handshake: start is accepted only on an edge where busy=0; done pulses for one
    // cycle with busy=0 and hi/lo already holding the new result.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           div_q;
    logic           neg_q, neg_r, dvz;
    logic [N-1:0]   a_mag, b_mag;
    logic [2*N-1:0] acc;
    logic [N-1:0]   rem;

    logic           sgn_a, sgn_b;
    logic [N-1:0]   mag_a, mag_b;
    logic [N:0]     mul_sum;
    logic [N:0]     div_shift, div_diff;
    logic           div_ge;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quot, remv;

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Operand magnitudes; the most-negative value maps onto 2^(N-1) unsigned.
    always_comb begin
        sgn_a = op[0] & srcA[N-1];
        sgn_b = op[0] & srcB[N-1];
        mag_a = sgn_a ? -srcA : srcA;
        mag_b = sgn_b ? -srcB : srcB;
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? a_mag : {N{1'b0}})};
        div_shift = {rem, acc[N-1]};
        div_ge    = (div_shift >= {1'b0, b_mag});
        div_diff  = div_shift - {1'b0, b_mag};
        prod      = neg_q ? -acc : acc;
        quot      = neg_q ? -acc[N-1:0] : acc[N-1:0];
        remv      = neg_r ? -rem : rem;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (cnt == CW'(N - 1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dvz   <= 1'b0;
            a_mag <= '0;
            b_mag <= '0;
            acc   <= '0;
            rem   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        div_q <= op[1];
                        neg_q <= sgn_a ^ sgn_b;
                        neg_r <= sgn_a;
                        dvz   <= op[1] && (srcB == '0);
                        a_mag <= mag_a;
                        b_mag <= mag_b;
                        cnt   <= '0;
                        rem   <= '0;
                        // Low half carries the multiplier or the dividend to be shifted out.
                        acc   <= {{N{1'b0}}, (op[1] ? mag_a : mag_b)};
                    end
                end
                S_CALC: begin
                    cnt <= (cnt == CW'(N - 1)) ? '0 : cnt + CW'(1);
                    if (div_q) begin
                        acc[N-1:0] <= {acc[N-2:0], div_ge};
                        rem        <= div_ge ? div_diff[N-1:0] : div_shift[N-1:0];
                    end else begin
                        acc <= {mul_sum, acc[N-1:1]};
                    end
                end
                S_FIX: begin
                    if (div_q) begin
                        lo <= dvz ? {N{1'b1}} : quot;
                        hi <= remv;
                    end else begin
                        hi <= prod[2*N-1:N];
                        lo <= prod[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: random and directed MULT/DIV traffic against an arithmetic
// reference model, plus MTHI/MTLO, ignored-start and mid-operation reset scenarios.
module tb_mult_div_unit;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] srcA, srcB;
  logic         hi_we, lo_we;
  logic [N-1:0] wdata;
  logic         busy, done;
  logic [N-1:0] hi, lo;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0;
  int busy_run = 0;
  logic [2*N-1:0] exp_q[$];
  int             cyc_q[$];
  logic [2*N-1:0] last_exp = '0;

  mult_div_unit #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [2*N-1:0] model(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'd0: p = {32'b0, a} * {32'b0, b};
      2'd1: p = sa * sb;
      2'd2: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    int g = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (busy) chk("issue_timeout", 1, 0);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
    last_exp = model(o, a, b);
    exp_q.push_back(last_exp);
    cyc_q.push_back(cyc + N + 2);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        chk("busy_len", busy_run, N + 1);
        busy_run = 0;
      end
      if (done) begin
        done_seen++;
        chk("done_busy_low", busy, 0);
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          chk("hilo", {hi, lo}, exp_q.pop_front());
          chk("latency", cyc, cyc_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0]   d_op [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0};
  logic [N-1:0] d_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'd100,
                             32'hFFFF_FFF9, 32'h8000_0000, 32'h1234, 32'd2};
  logic [N-1:0] d_b  [8] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd7,
                             32'd2, 32'hFFFF_FFFF, 32'd0, 32'd3};

  initial begin
    int seen0;
    reset = 1'b1; start = 1'b0; op = '0; srcA = '0; srcB = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed corner cases, issued back to back.
    for (int i = 0; i < 8; i++) issue(d_op[i], d_a[i], d_b[i]);
    drain();
    chk("multu_max_const", {hi, lo}, 64'h0000_0000_0000_0006);

    // MTHI while idle.
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'hA5A5_A5A5);
    chk("mthi_lo_kept", lo, last_exp[N-1:0]);

    // start and MTLO while busy are ignored.
    issue(2'd1, 32'hFFFF_FFFD, 32'd5);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd2; srcA = 32'd999; srcB = 32'd4;
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("hold_after_ignored", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    // Asynchronous reset mid-operation.
    issue(2'd0, $urandom, $urandom);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    exp_q.delete();
    cyc_q.delete();
    seen0 = done_seen;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (N + 10) @(negedge clk);
    chk("no_done_after_reset", done_seen, seen0);
    issue(2'd0, 32'd2, 32'd3);
    drain();
    chk("post_reset_lo", lo, 32'd6);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) issue(2'($urandom_range(0, 3)), pick(), pick());
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
